// File: rtl/conv_pkg.sv
// Shared types and constants for the conv_net kernel configuration path.
// Latency: none (package only).
// Backpressure: none (package only).
package conv_pkg;

    // Coefficient bit width: integer + fraction + optional sign bit.
    function automatic int kbd(input int m, input int n, input int s);
        return m + n + s;
    endfunction

    // Index width that stays legal for a single-entry dimension.
    function automatic int idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } kctrl_state_t;

    // Identity kernel tap: 1.0 at the centre, 0 elsewhere.
    function automatic logic [31:0] identity_tap(input int y, input int x,
                                                 input int kh, input int kw,
                                                 input int n);
        return ((y == kh / 2) && (x == kw / 2)) ? (32'd1 << n) : 32'd0;
    endfunction

endpackage

// File: rtl/frame_boundary_det.sv
// End-of-frame detector: flags the last valid pixel of a frame.
// Latency: combinational, eof is high in the same cycle as that pixel.
// Backpressure: none; purely observes the stream.
module frame_boundary_det #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        pix_valid,
    input  logic [15:0] pix_row,
    input  logic [15:0] pix_col,
    output logic        eof
);

    localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
    localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);

    assign eof = pix_valid && (pix_row == LAST_ROW) && (pix_col == LAST_COL);

endmodule

// File: rtl/conv_kernel_ctrl.sv
// Double-buffered kernel coefficient bank; shadow copied to active at frame end.
// Latency: active bank and swap_o change one cycle after the EOF pixel.
// Backpressure: busy_o high while a commit is pending; writes/commits then dropped with wr_err_o.
module conv_kernel_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int K_WIDTH     = 3,
    parameter int K_HEIGHT    = 3,
    parameter int FP_M_KERNEL = 4,
    parameter int FP_N_KERNEL = 8,
    parameter int FP_S_KERNEL = 0
) (
    input  logic                                   pclk,
    input  logic                                   rst_n_i,
    input  logic                                   wr_en_i,
    input  logic [idx_w(K_HEIGHT)-1:0]             wr_y_i,
    input  logic [idx_w(K_WIDTH)-1:0]              wr_x_i,
    input  logic [kbd(FP_M_KERNEL, FP_N_KERNEL, FP_S_KERNEL)-1:0] wr_data_i,
    input  logic                                   commit_i,
    output logic                                   busy_o,
    output logic                                   wr_err_o,
    input  logic                                   pix_valid_i,
    input  logic [15:0]                            pix_row_i,
    input  logic [15:0]                            pix_col_i,
    output logic [K_HEIGHT-1:0][K_WIDTH-1:0][kbd(FP_M_KERNEL, FP_N_KERNEL, FP_S_KERNEL)-1:0] kernel_coeffs_o,
    output logic                                   swap_o,
    output logic [7:0]                             swap_cnt_o
);

    localparam int KB = kbd(FP_M_KERNEL, FP_N_KERNEL, FP_S_KERNEL);

    typedef logic [K_HEIGHT-1:0][K_WIDTH-1:0][KB-1:0] bank_t;

    bank_t        shadow;
    bank_t        active;
    kctrl_state_t state;
    logic         eof;
    logic         in_range;

    frame_boundary_det #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_eof (
        .pix_valid (pix_valid_i),
        .pix_row   (pix_row_i),
        .pix_col   (pix_col_i),
        .eof       (eof)
    );

    // Non-power-of-two kernels leave unused index codes; those writes are rejected.
    assign in_range = (int'(wr_y_i) < K_HEIGHT) && (int'(wr_x_i) < K_WIDTH);

    assign busy_o          = (state != IDLE);
    assign kernel_coeffs_o = active;

    // Commit FSM plus both banks; active is only ever loaded on the PENDING->SWAP edge.
    always_ff @(posedge pclk) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            swap_o     <= 1'b0;
            wr_err_o   <= 1'b0;
            swap_cnt_o <= 8'd0;
            for (int y = 0; y < K_HEIGHT; y++) begin
                for (int x = 0; x < K_WIDTH; x++) begin
                    shadow[y][x] <= KB'(identity_tap(y, x, K_HEIGHT, K_WIDTH, FP_N_KERNEL));
                    active[y][x] <= KB'(identity_tap(y, x, K_HEIGHT, K_WIDTH, FP_N_KERNEL));
                end
            end
        end else begin
            swap_o   <= 1'b0;
            wr_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // A write in the commit cycle lands in shadow before the copy.
                    if (wr_en_i) begin
                        if (in_range) begin
                            shadow[wr_y_i][wr_x_i] <= wr_data_i;
                        end else begin
                            wr_err_o <= 1'b1;
                        end
                    end
                    // EOF in this cycle is deliberately not considered: it belongs to the old frame.
                    if (commit_i) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (wr_en_i || commit_i) begin
                        wr_err_o <= 1'b1;
                    end
                    if (eof) begin
                        state      <= SWAP;
                        active     <= shadow;
                        swap_o     <= 1'b1;
                        swap_cnt_o <= swap_cnt_o + 8'd1;
                    end
                end
                SWAP: begin
                    if (wr_en_i || commit_i) begin
                        wr_err_o <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_ctrl.sv
// Self-checking bench for conv_kernel_ctrl with a transaction-level reference model.
// Latency: model predicts outputs one cycle after each driven input set.
// Backpressure: model tracks the pending commit and dropped host accesses.
module tb_conv_kernel_ctrl;

    logic              pclk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [1:0]        wy;
    logic [1:0]        wx;
    logic [11:0]       wd;
    logic              commit;
    logic              busy;
    logic              err;
    logic              pv;
    logic [15:0]       prow;
    logic [15:0]       pcol;
    logic [2:0][2:0][11:0] coeffs;
    logic              swp;
    logic [7:0]        cnt;

    // reference model state
    logic [2:0][2:0][11:0] ident;
    logic [2:0][2:0][11:0] m_shadow;
    logic [2:0][2:0][11:0] m_active;
    bit                m_pending;
    bit                m_inswap;
    bit                m_err;
    int                m_cnt;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    conv_kernel_ctrl dut (
        .pclk            (pclk),
        .rst_n_i         (rst_n),
        .wr_en_i         (wr_en),
        .wr_y_i          (wy),
        .wr_x_i          (wx),
        .wr_data_i       (wd),
        .commit_i        (commit),
        .busy_o          (busy),
        .wr_err_o        (err),
        .pix_valid_i     (pv),
        .pix_row_i       (prow),
        .pix_col_i       (pcol),
        .kernel_coeffs_o (coeffs),
        .swap_o          (swp),
        .swap_cnt_o      (cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: update the model from the rules using the inputs of this cycle, then compare.
    task automatic cyc();
        bit eof;
        bit was_busy;
        bit ok_idx;
        @(posedge pclk);
        if (!rst_n) begin
            m_shadow  = ident;
            m_active  = ident;
            m_pending = 0;
            m_inswap  = 0;
            m_err     = 0;
            m_cnt     = 0;
        end else begin
            was_busy = m_pending || m_inswap;
            eof      = pv && (prow == 16'd479) && (pcol == 16'd639);
            ok_idx   = (wy < 2'd3) && (wx < 2'd3);
            m_err    = (was_busy && (wr_en || commit)) || (!was_busy && wr_en && !ok_idx);
            if (!was_busy && wr_en && ok_idx) m_shadow[wy][wx] = wd;
            m_inswap = m_pending && eof;
            if (m_inswap) begin
                m_active  = m_shadow;
                m_cnt     = (m_cnt + 1) % 256;
                m_pending = 0;
            end else if (!was_busy && commit) begin
                m_pending = 1;
            end
        end
        #1;
        chk("busy",   {127'd0, busy}, {127'd0, (m_pending || m_inswap)});
        chk("swap",   {127'd0, swp},  {127'd0, m_inswap});
        chk("wr_err", {127'd0, err},  {127'd0, m_err});
        chk("cnt",    {120'd0, cnt},  {120'd0, 8'(m_cnt)});
        chk("coeffs", {20'd0, coeffs}, {20'd0, m_active});
    endtask

    task automatic drive(input bit we, input int y, input int x, input int d,
                         input bit cm, input bit v, input int r, input int c);
        wr_en  = we;
        wy     = 2'(y);
        wx     = 2'(x);
        wd     = 12'(d);
        commit = cm;
        pv     = v;
        prow   = 16'(r);
        pcol   = 16'(c);
        cyc();
    endtask

    // Host quiet, pixel noise that never hits the last row.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 0, 0, 0, 1'($urandom), $urandom_range(0, 478), $urandom_range(0, 639));
    endtask

    task automatic do_write(input int y, input int x, input int d);
        drive(1, y, x, d, 0, 0, 0, 0);
    endtask

    task automatic do_commit();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Near-miss pixels, then the real EOF pixel.
    task automatic frame_end();
        drive(0, 0, 0, 0, 0, 1, 479, 638);
        drive(0, 0, 0, 0, 0, 1, 478, 639);
        drive(0, 0, 0, 0, 0, 0, 479, 639);
        drive(0, 0, 0, 0, 0, 1, 479, 639);
    endtask

    initial begin
        ident       = '0;
        ident[1][1] = 12'h100;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 479, 639);
        rst_n = 1'b1;

        // T1 reset values
        chk("rst_centre", {116'd0, coeffs[1][1]}, {116'd0, 12'h100});
        chk("rst_corner", {116'd0, coeffs[0][0]}, 128'd0);
        chk("rst_busy",   {127'd0, busy}, 128'd0);
        chk("rst_cnt",    {120'd0, cnt},  128'd0);
        idle(3);

        // T2 write, commit, swap one cycle after EOF
        do_write(0, 0, 12'h080);
        do_commit();
        idle(4);
        frame_end();
        chk("t2_swap_pulse", {127'd0, swp}, 128'd1);
        chk("t2_tap00", {116'd0, coeffs[0][0]}, {116'd0, 12'h080});
        chk("t2_cnt",   {120'd0, cnt}, 128'd1);
        idle(1);
        chk("t2_swap_low", {127'd0, swp}, 128'd0);
        chk("t2_busy_low", {127'd0, busy}, 128'd0);

        // T3 write while busy is dropped
        do_commit();
        do_write(2, 2, 12'h0FF);
        chk("t3_err", {127'd0, err}, 128'd1);
        idle(2);
        frame_end();
        idle(1);
        chk("t3_tap22", {116'd0, coeffs[2][2]}, 128'd0);
        chk("t3_tap00", {116'd0, coeffs[0][0]}, {116'd0, 12'h080});

        // T4 commit in the EOF cycle waits for the next frame
        do_write(0, 1, 12'h123);
        drive(0, 0, 0, 0, 1, 1, 479, 639);
        chk("t4_no_swap", {127'd0, swp}, 128'd0);
        chk("t4_busy", {127'd0, busy}, 128'd1);
        idle(5);
        chk("t4_busy_hold", {127'd0, busy}, 128'd1);
        frame_end();
        chk("t4_swap", {127'd0, swp}, 128'd1);
        chk("t4_tap01", {116'd0, coeffs[0][1]}, {116'd0, 12'h123});
        idle(1);

        // T5 reset cancels a pending commit
        do_write(1, 0, 12'h055);
        do_commit();
        idle(3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("t5_busy", {127'd0, busy}, 128'd0);
        frame_end();
        chk("t5_no_swap", {127'd0, swp}, 128'd0);
        chk("t5_ident", {20'd0, coeffs}, {20'd0, ident});
        idle(1);

        // T6 256 randomized commit/EOF rounds, out-of-range indices included
        for (int k = 0; k < 256; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0)
                drive(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4095), 1, 0, 0, 0);
            else
                do_commit();
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4095));
            drive(0, 0, 0, 0, 0, 1, 479, 639);
            chk("t6_swap", {127'd0, swp}, 128'd1);
            idle(1);
            chk("t6_swap_width", {127'd0, swp}, 128'd0);
        end
        chk("t6_wrap", {120'd0, cnt}, 128'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
